// File: rtl/trap_pc_sequencer.sv
// trap_pc_sequencer
//   Next-PC and trap sequencer for the fetch path. In normal operation it
//   forwards the PC-select mux (I_privsel ? I_data2 : I_data1).
//   It prioritises synchronous exceptions over latched, masked interrupts.
//   When a trap is accepted it records mcause/mepc and redirects fetch to
//   the trap vector for exactly one cycle (ENTER). It then stays in HANDLER
//   until mret returns fetch to mepc.
//
// Ports
//   I_clk, I_rst_n         clock (rising edge), asynchronous active-low reset
//   I_stall                freezes trap acceptance and mret; pending capture
//                          continues during a stall
//   I_privsel, I_data1/2   normal next-PC select and its two candidates
//   I_pc                   PC of the instruction in the decision stage
//   I_exc                  exception requests; index 0 has the highest priority
//   I_irq, I_irq_en, I_mie raw interrupt lines, per-line enables, global enable
//   I_mtvec                trap vector base; bits [1:0] hold the mode field
//   I_mret                 mret executing in the decision stage
//   O_data                 next fetch PC
//   O_trap_taken           high during the ENTER cycle
//   O_in_handler           high in ENTER and HANDLER
//   O_mcause, O_mepc       recorded trap cause and return PC
//   O_irq_pending          pending-interrupt latch
//
// Build option
//   VECTORED_TRAP_EN  When this macro is defined and I_mtvec[1:0]==2'b01,
//                     interrupt k vectors to base + 4*k. Otherwise every
//                     trap uses base.
module trap_pc_sequencer #(
   parameter int XLEN    = 32,
   parameter int NUM_EXC = 4,
   parameter int NUM_IRQ = 4
) (
   input  logic               I_clk,
   input  logic               I_rst_n,
   input  logic               I_stall,
   input  logic               I_privsel,
   input  logic [XLEN-1:0]    I_data1,
   input  logic [XLEN-1:0]    I_data2,
   input  logic [XLEN-1:0]    I_pc,
   input  logic [NUM_EXC-1:0] I_exc,
   input  logic [NUM_IRQ-1:0] I_irq,
   input  logic [NUM_IRQ-1:0] I_irq_en,
   input  logic               I_mie,
   input  logic [XLEN-1:0]    I_mtvec,
   input  logic               I_mret,
   output logic [XLEN-1:0]    O_data,
   output logic               O_trap_taken,
   output logic               O_in_handler,
   output logic [XLEN-1:0]    O_mcause,
   output logic [XLEN-1:0]    O_mepc,
   output logic [NUM_IRQ-1:0] O_irq_pending
);

   typedef enum logic [1:0] {IDLE, ENTER, HANDLER} state_t;

   localparam logic [XLEN-1:0] IRQ_FLAG = {1'b1, {(XLEN-1){1'b0}}};

   state_t             state;
   logic [XLEN-1:0]    mcause;
   logic [XLEN-1:0]    mepc;
   logic [XLEN-1:0]    trap_vec;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] irq_prev;

   logic               exc_hit;
   logic               irq_hit;
   logic               decide;
   logic               mret_ret;
   logic [XLEN-1:0]    exc_idx;
   logic [XLEN-1:0]    irq_idx;
   logic [NUM_IRQ-1:0] irq_req;
   logic [NUM_IRQ-1:0] irq_oh;
   logic [NUM_IRQ-1:0] irq_rise;
   logic [NUM_IRQ-1:0] clr_mask;
   logic [XLEN-1:0]    base;
   logic [XLEN-1:0]    vec_irq;
   logic [XLEN-1:0]    normal_pc;

   // The loops scan from the highest index down, so the lowest set index
   // is the last one written and wins.
   always_comb begin
      exc_idx = '0;
      for (int i = NUM_EXC - 1; i >= 0; i--) begin
         if (I_exc[i]) exc_idx = XLEN'(i);
      end
      irq_req = pending & I_irq_en;
      irq_idx = '0;
      irq_oh  = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq_req[i]) begin
            irq_idx   = XLEN'(i);
            irq_oh    = '0;
            irq_oh[i] = 1'b1;
         end
      end
   end

   assign exc_hit  = |I_exc;
   assign irq_hit  = (state == IDLE) && I_mie && (|irq_req);
   assign decide   = ((state == IDLE) || (state == HANDLER)) && !I_stall &&
                     (exc_hit || irq_hit);
   assign mret_ret = (state == HANDLER) && !I_stall && I_mret && !exc_hit;

   // A pending bit is cleared only when its interrupt is the one accepted.
   // A simultaneous new edge re-sets the bit because the rise mask is ORed in last.
   assign irq_rise = I_irq & ~irq_prev;
   assign clr_mask = (decide && !exc_hit) ? irq_oh : '0;

   assign base = {I_mtvec[XLEN-1:2], 2'b00};
`ifdef VECTORED_TRAP_EN
   assign vec_irq = (I_mtvec[1:0] == 2'b01) ? base + (irq_idx << 2) : base;
`else
   assign vec_irq = base;
`endif

   assign normal_pc = I_privsel ? I_data2 : I_data1;

   always_comb begin
      O_data = normal_pc;
      if (state == ENTER)  O_data = trap_vec;
      else if (mret_ret)   O_data = mepc;
   end

   assign O_trap_taken  = (state == ENTER);
   assign O_in_handler  = (state != IDLE);
   assign O_mcause      = mcause;
   assign O_mepc        = mepc;
   assign O_irq_pending = pending;

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state    <= IDLE;
         mcause   <= '0;
         mepc     <= '0;
         trap_vec <= '0;
         pending  <= '0;
         irq_prev <= '0;
      end else begin
         irq_prev <= I_irq;
         pending  <= (pending & ~clr_mask) | irq_rise;
         case (state)
            // The redirect cycle always completes, even under stall.
            ENTER: state <= HANDLER;
            IDLE, HANDLER: begin
               if (decide) begin
                  state    <= ENTER;
                  mepc     <= I_pc;
                  mcause   <= exc_hit ? exc_idx : (IRQ_FLAG | irq_idx);
                  trap_vec <= exc_hit ? base : vec_irq;
               end else if (mret_ret) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_pc_sequencer.sv
// Testbench for trap_pc_sequencer: directed scenarios plus a randomized run
// checked against a behavioural model of the trap rules.
module tb_trap_pc_sequencer;

   localparam int XLEN = 32;
`ifdef VECTORED_TRAP_EN
   localparam bit VEC = 1'b1;
`else
   localparam bit VEC = 1'b0;
`endif

   logic            I_clk, I_rst_n, I_stall, I_privsel, I_mie, I_mret;
   logic [XLEN-1:0] I_data1, I_data2, I_pc, I_mtvec;
   logic [3:0]      I_exc, I_irq, I_irq_en;
   logic [XLEN-1:0] O_data, O_mcause, O_mepc;
   logic            O_trap_taken, O_in_handler;
   logic [3:0]      O_irq_pending;

   int n_checks = 0;
   int n_fail   = 0;

   trap_pc_sequencer #(.XLEN(XLEN), .NUM_EXC(4), .NUM_IRQ(4)) dut (
      .I_clk(I_clk), .I_rst_n(I_rst_n), .I_stall(I_stall), .I_privsel(I_privsel),
      .I_data1(I_data1), .I_data2(I_data2), .I_pc(I_pc), .I_exc(I_exc),
      .I_irq(I_irq), .I_irq_en(I_irq_en), .I_mie(I_mie), .I_mtvec(I_mtvec),
      .I_mret(I_mret), .O_data(O_data), .O_trap_taken(O_trap_taken),
      .O_in_handler(O_in_handler), .O_mcause(O_mcause), .O_mepc(O_mepc),
      .O_irq_pending(O_irq_pending)
   );

   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   task automatic idle_inputs();
      I_stall = 0; I_privsel = 0; I_data1 = 32'h0; I_data2 = 32'h0; I_pc = 32'h0;
      I_exc = 0; I_irq = 0; I_irq_en = 4'hF; I_mie = 0; I_mtvec = 32'h8000; I_mret = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      I_rst_n = 0;
      #3;
      I_rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      I_rst_n = 0; I_privsel = 1; I_data2 = 32'h200;
      #1;
      n_checks++; if (O_data !== 32'h200) begin n_fail++; $display("FAIL reset_data got=%h exp=%h", O_data, 32'h200); end
      n_checks++; if (O_mcause !== 32'h0) begin n_fail++; $display("FAIL reset_mcause got=%h exp=0", O_mcause); end
      n_checks++; if (O_mepc !== 32'h0) begin n_fail++; $display("FAIL reset_mepc got=%h exp=0", O_mepc); end
      n_checks++; if (O_trap_taken !== 1'b0) begin n_fail++; $display("FAIL reset_trap got=%b exp=0", O_trap_taken); end
      n_checks++; if (O_irq_pending !== 4'h0) begin n_fail++; $display("FAIL reset_pending got=%h exp=0", O_irq_pending); end
      #3; I_rst_n = 1;
      tick();
      n_checks++; if (O_in_handler !== 1'b0) begin n_fail++; $display("FAIL reset_idle got=%b exp=0", O_in_handler); end
      n_checks++; if (O_data !== 32'h200) begin n_fail++; $display("FAIL reset_idle_data got=%h exp=%h", O_data, 32'h200); end
   endtask

   task automatic test_exc_priority();
      do_reset();
      I_exc = 4'b0110; I_pc = 32'h1000; I_mtvec = 32'h8000;
      tick();
      I_exc = 0;
      #1;
      n_checks++; if (O_trap_taken !== 1'b1) begin n_fail++; $display("FAIL excp_trap got=%b exp=1", O_trap_taken); end
      n_checks++; if (O_data !== 32'h8000) begin n_fail++; $display("FAIL excp_data got=%h exp=8000", O_data); end
      n_checks++; if (O_mcause !== 32'h1) begin n_fail++; $display("FAIL excp_mcause got=%h exp=1", O_mcause); end
      n_checks++; if (O_mepc !== 32'h1000) begin n_fail++; $display("FAIL excp_mepc got=%h exp=1000", O_mepc); end
      tick();
      n_checks++; if (O_in_handler !== 1'b1) begin n_fail++; $display("FAIL excp_handler got=%b exp=1", O_in_handler); end
      n_checks++; if (O_trap_taken !== 1'b0) begin n_fail++; $display("FAIL excp_trap_drop got=%b exp=0", O_trap_taken); end
      I_mret = 1; I_data1 = 32'h5554;
      #1;
      n_checks++; if (O_data !== 32'h1000) begin n_fail++; $display("FAIL excp_mret_data got=%h exp=1000", O_data); end
      tick();
      I_mret = 0;
      n_checks++; if (O_in_handler !== 1'b0) begin n_fail++; $display("FAIL excp_return got=%b exp=0", O_in_handler); end
   endtask

   task automatic test_irq_vs_exc();
      do_reset();
      I_irq = 4'b0100; tick();
      I_irq = 0; tick();
      n_checks++; if (O_irq_pending !== 4'b0100) begin n_fail++; $display("FAIL ive_latch got=%h exp=4", O_irq_pending); end
      I_mie = 1; I_exc = 4'b1000; I_pc = 32'h2000;
      tick();
      I_exc = 0;
      n_checks++; if (O_mcause !== 32'h3) begin n_fail++; $display("FAIL ive_mcause got=%h exp=3", O_mcause); end
      n_checks++; if (O_irq_pending !== 4'b0100) begin n_fail++; $display("FAIL ive_keep got=%h exp=4", O_irq_pending); end
      tick(); tick();
      n_checks++; if (O_in_handler !== 1'b1 || O_trap_taken !== 1'b0) begin n_fail++; $display("FAIL ive_masked hnd=%b trap=%b exp=1/0", O_in_handler, O_trap_taken); end
      I_mret = 1;
      #1;
      n_checks++; if (O_data !== 32'h2000) begin n_fail++; $display("FAIL ive_mret got=%h exp=2000", O_data); end
      tick();
      I_mret = 0;
      tick();
      n_checks++; if (O_mcause !== 32'h80000002) begin n_fail++; $display("FAIL ive_irq_cause got=%h exp=80000002", O_mcause); end
      n_checks++; if (O_trap_taken !== 1'b1) begin n_fail++; $display("FAIL ive_irq_trap got=%b exp=1", O_trap_taken); end
      n_checks++; if (O_irq_pending !== 4'b0000) begin n_fail++; $display("FAIL ive_cleared got=%h exp=0", O_irq_pending); end
   endtask

   task automatic test_masking();
      do_reset();
      I_irq = 4'b0010; tick();
      I_irq = 0; tick(); tick();
      n_checks++; if (O_irq_pending !== 4'b0010) begin n_fail++; $display("FAIL mask_latch got=%h exp=2", O_irq_pending); end
      n_checks++; if (O_in_handler !== 1'b0) begin n_fail++; $display("FAIL mask_notrap got=%b exp=0", O_in_handler); end
      I_mie = 1; I_pc = 32'h3000;
      tick();
      n_checks++; if (O_trap_taken !== 1'b1 || O_mcause !== 32'h80000001) begin n_fail++; $display("FAIL mask_take trap=%b cause=%h exp=1/80000001", O_trap_taken, O_mcause); end
      n_checks++; if (O_irq_pending !== 4'b0000) begin n_fail++; $display("FAIL mask_clear got=%h exp=0", O_irq_pending); end
      tick();
      I_irq = 4'b0001; tick();
      I_irq = 0; tick();
      n_checks++; if (O_irq_pending !== 4'b0001 || O_trap_taken !== 1'b0) begin n_fail++; $display("FAIL mask_hnd pend=%h trap=%b exp=1/0", O_irq_pending, O_trap_taken); end
      I_mret = 1; tick();
      I_mret = 0; tick();
      n_checks++; if (O_mcause !== 32'h80000000 || O_trap_taken !== 1'b1) begin n_fail++; $display("FAIL mask_after cause=%h trap=%b exp=80000000/1", O_mcause, O_trap_taken); end
   endtask

   task automatic test_edge_vs_clear();
      do_reset();
      // Accept irq 1 while a new edge arrives on the same line: the bit stays set.
      I_irq = 4'b0010; tick();
      I_irq = 0; tick();
      I_mie = 1; I_irq = 4'b0010;
      tick();
      I_irq = 0;
      n_checks++; if (O_trap_taken !== 1'b1 || O_irq_pending !== 4'b0010) begin n_fail++; $display("FAIL edge_wins trap=%b pend=%h exp=1/2", O_trap_taken, O_irq_pending); end
   endtask

   task automatic test_mret_stall();
      do_reset();
      I_exc = 4'b0001; I_pc = 32'h1000; I_mtvec = 32'h8000;
      tick();
      I_exc = 0; I_stall = 1;
      #1;
      n_checks++; if (O_data !== 32'h8000 || O_trap_taken !== 1'b1) begin n_fail++; $display("FAIL stall_enter data=%h trap=%b exp=8000/1", O_data, O_trap_taken); end
      tick();
      n_checks++; if (O_in_handler !== 1'b1 || O_trap_taken !== 1'b0) begin n_fail++; $display("FAIL stall_handler hnd=%b trap=%b exp=1/0", O_in_handler, O_trap_taken); end
      I_mret = 1; I_data1 = 32'h444;
      #1;
      n_checks++; if (O_data !== 32'h444) begin n_fail++; $display("FAIL stall_mret_data got=%h exp=444", O_data); end
      tick();
      n_checks++; if (O_in_handler !== 1'b1) begin n_fail++; $display("FAIL stall_mret_hold got=%b exp=1", O_in_handler); end
      I_stall = 0;
      #1;
      n_checks++; if (O_data !== 32'h1000) begin n_fail++; $display("FAIL unstall_mret got=%h exp=1000", O_data); end
      tick();
      I_mret = 0;
      n_checks++; if (O_in_handler !== 1'b0) begin n_fail++; $display("FAIL unstall_idle got=%b exp=0", O_in_handler); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      I_exc = 4'b0100; I_pc = 32'h3000; I_data1 = 32'h4444;
      tick();
      I_exc = 0;
      #2; I_rst_n = 0;
      #1;
      n_checks++; if (O_trap_taken !== 1'b0 || O_in_handler !== 1'b0) begin n_fail++; $display("FAIL midrst_state trap=%b hnd=%b exp=0/0", O_trap_taken, O_in_handler); end
      n_checks++; if (O_data !== 32'h4444 || O_mcause !== 32'h0) begin n_fail++; $display("FAIL midrst_out data=%h cause=%h exp=4444/0", O_data, O_mcause); end
      I_rst_n = 1;
      tick();
      n_checks++; if (O_in_handler !== 1'b0) begin n_fail++; $display("FAIL midrst_after got=%b exp=0", O_in_handler); end
   endtask

   task automatic test_vector();
      logic [XLEN-1:0] exp_v;
      do_reset();
      I_mtvec = 32'h8001; I_mie = 1;
      exp_v = VEC ? 32'h800C : 32'h8000;
      I_irq = 4'b1000; tick();
      I_irq = 0; tick();
      n_checks++; if (O_data !== exp_v || O_mcause !== 32'h80000003) begin n_fail++; $display("FAIL vec_irq data=%h cause=%h exp=%h/80000003", O_data, O_mcause, exp_v); end
      tick();
      I_mret = 1; tick();
      I_mret = 0; I_exc = 4'b0100; tick();
      I_exc = 0;
      n_checks++; if (O_data !== 32'h8000 || O_mcause !== 32'h2) begin n_fail++; $display("FAIL vec_exc data=%h cause=%h exp=8000/2", O_data, O_mcause); end
   endtask

   // Randomized run against a behavioural model of the trap rules.
   task automatic test_random();
      int              mode;        // 0 normal, 1 redirect cycle, 2 in handler
      logic [XLEN-1:0] m_cause, m_epc, m_vec, exp_data, base;
      logic [3:0]      m_pend, m_prev, cand;
      int              k;
      do_reset();
      mode = 0; m_cause = 0; m_epc = 0; m_vec = 0; m_pend = 0; m_prev = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc == 300) begin
            #2; I_rst_n = 0;
            #1;
            n_checks++; if (O_in_handler !== 1'b0 || O_mepc !== 32'h0) begin n_fail++; $display("FAIL rnd_reset hnd=%b mepc=%h exp=0/0", O_in_handler, O_mepc); end
            I_rst_n = 1;
            mode = 0; m_cause = 0; m_epc = 0; m_vec = 0; m_pend = 0; m_prev = 0;
         end
         I_stall   = ($urandom_range(0, 4) == 0);
         I_privsel = 1'($urandom);
         I_data1   = $urandom; I_data2 = $urandom; I_pc = $urandom;
         I_exc     = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
         I_irq     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : I_irq;
         I_irq_en  = 4'($urandom);
         I_mie     = ($urandom_range(0, 2) != 0);
         I_mret    = ($urandom_range(0, 2) == 0);
         I_mtvec   = $urandom;
         #1;
         if (mode == 1) exp_data = m_vec;
         else if (mode == 2 && !I_stall && I_mret && I_exc == 0) exp_data = m_epc;
         else exp_data = I_privsel ? I_data2 : I_data1;
         n_checks++; if (O_data !== exp_data) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, O_data, exp_data); end
         // next-state per the trap rules
         base = I_mtvec & ~32'h3;
         cand = m_pend & I_irq_en;
         if (mode == 1) begin
            mode = 2;
         end else if (!I_stall && I_exc != 0) begin
            k = 0; while (!I_exc[k]) k++;
            m_cause = k; m_epc = I_pc; m_vec = base; mode = 1;
         end else if (!I_stall && mode == 0 && I_mie && cand != 0) begin
            k = 0; while (!cand[k]) k++;
            m_cause = 32'h80000000 + k; m_epc = I_pc;
            m_vec = (VEC && I_mtvec[1:0] == 2'b01) ? base + 4 * k : base;
            m_pend[k] = 1'b0; mode = 1;
         end else if (!I_stall && mode == 2 && I_mret) begin
            mode = 0;
         end
         m_pend = m_pend | (I_irq & ~m_prev);
         m_prev = I_irq;
         tick();
         n_checks++; if (O_mcause !== m_cause || O_mepc !== m_epc) begin n_fail++; $display("FAIL rnd_regs cyc=%0d cause=%h epc=%h exp=%h/%h", cyc, O_mcause, O_mepc, m_cause, m_epc); end
         n_checks++; if (O_irq_pending !== m_pend) begin n_fail++; $display("FAIL rnd_pend cyc=%0d got=%h exp=%h", cyc, O_irq_pending, m_pend); end
         n_checks++; if (O_trap_taken !== (mode == 1) || O_in_handler !== (mode != 0)) begin n_fail++; $display("FAIL rnd_state cyc=%0d trap=%b hnd=%b exp_mode=%0d", cyc, O_trap_taken, O_in_handler, mode); end
      end
   endtask

   initial begin
      idle_inputs();
      I_rst_n = 0;
      test_reset();
      test_exc_priority();
      test_irq_vs_exc();
      test_masking();
      test_edge_vs_clear();
      test_mret_stall();
      test_reset_mid();
      test_vector();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
